// File: rtl/twist_counter_gen.sv
// Parametrised Johnson (twisted-ring) counter with enable, direction, parallel
// load, phase decode, wrap pulse and illegal-state detection/correction.
module twist_counter_gen #(
    parameter int unsigned WIDTH        = 8,
    parameter bit          SELF_CORRECT = 1'b1,
    parameter int unsigned PW           = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic [PW-1:0]    phase,
    output logic             wrap,
    output logic             illegal,
    output logic             err
);

    localparam int unsigned SEQ_LEN   = 2 * WIDTH;
    localparam logic [PW-1:0] LAST_PH = PW'(SEQ_LEN - 1);

    // A Johnson word has at most one boundary between a run of ones and zeros.
    function automatic logic is_legal(input logic [WIDTH-1:0] w);
        int unsigned edges;
        edges = 0;
        for (int unsigned i = 0; i < WIDTH - 1; i++) begin
            if (w[i] != w[i+1]) edges++;
        end
        return (edges <= 1);
    endfunction

    // Position in the sequence: ones count on the rising half, WIDTH + zeros
    // count on the falling half (MSB set).
    function automatic logic [PW-1:0] decode_phase(input logic [WIDTH-1:0] w);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (w[i]) ones++;
        end
        if (w[WIDTH-1]) return PW'(WIDTH + (WIDTH - ones));
        return PW'(ones);
    endfunction

    logic [WIDTH-1:0] cnt_nxt;
    logic             wrap_nxt;
    logic             err_nxt;
    logic [WIDTH-1:0] fwd_word;
    logic [WIDTH-1:0] rev_word;
    logic             load_ok;

    // Status decode of the current word; depends on cnt only.
    always_comb begin
        illegal = ~is_legal(cnt);
        phase   = decode_phase(cnt);
    end

    // Successor and predecessor words, plus legality of the load value.
    always_comb begin
        fwd_word = {cnt[WIDTH-2:0], ~cnt[WIDTH-1]};
        rev_word = {~cnt[0], cnt[WIDTH-1:1]};
        load_ok  = is_legal(load_val);
    end

    // Next-state selection: load > step > hold.
    always_comb begin
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        err_nxt  = err;
        if (load) begin
            if (load_ok) begin
                cnt_nxt = load_val;
                err_nxt = 1'b0;
            end else begin
                cnt_nxt = SELF_CORRECT ? '0 : load_val;
                err_nxt = 1'b1;
            end
        end else if (en) begin
            if (illegal) begin
                // Wrap is not meaningful for a word with no defined phase.
                cnt_nxt = SELF_CORRECT ? '0 : (up ? fwd_word : rev_word);
                err_nxt = 1'b1;
            end else begin
                cnt_nxt  = up ? fwd_word : rev_word;
                wrap_nxt = up ? (phase == LAST_PH) : (phase == '0);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            wrap <= 1'b0;
            err  <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            wrap <= wrap_nxt;
            err  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_twist_counter_gen.sv
// Randomised self-checking bench for twist_counter_gen: WIDTH=8 in both
// correction modes plus a WIDTH=2 build, against a phase-table reference model.
module tb_twist_counter_gen;

    logic       clk = 1'b0;
    logic       rst, en, up, load;
    logic [7:0] load_val;

    logic [7:0] cnt_a, cnt_b;
    logic [3:0] phase_a, phase_b;
    logic       wrap_a, wrap_b, illegal_a, illegal_b, err_a, err_b;
    logic [1:0] cnt_c, phase_c, load_val_c;
    logic       wrap_c, illegal_c, err_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign load_val_c = load_val[1:0];

    twist_counter_gen #(.WIDTH(8), .SELF_CORRECT(1'b1)) u_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .cnt(cnt_a), .phase(phase_a), .wrap(wrap_a), .illegal(illegal_a), .err(err_a));

    twist_counter_gen #(.WIDTH(8), .SELF_CORRECT(1'b0)) u_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .cnt(cnt_b), .phase(phase_b), .wrap(wrap_b), .illegal(illegal_b), .err(err_b));

    twist_counter_gen #(.WIDTH(2), .SELF_CORRECT(1'b1)) u_c (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val_c),
        .cnt(cnt_c), .phase(phase_c), .wrap(wrap_c), .illegal(illegal_c), .err(err_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: state kept as a raw word, behaviour derived from the
    // table of legal words indexed by phase.
    int unsigned m_w [3] = '{8, 8, 2};
    bit          m_sc[3] = '{1'b1, 1'b0, 1'b1};
    int unsigned m_cnt[3];
    bit          m_wrap[3];
    bit          m_err[3];

    function automatic int unsigned word_at(input int unsigned w, input int unsigned p);
        int unsigned mask;
        mask = (1 << w) - 1;
        if (p < w) return (1 << p) - 1;
        return mask ^ ((1 << (p - w)) - 1);
    endfunction

    function automatic int phase_of(input int unsigned w, input int unsigned v);
        for (int p = 0; p < int'(2 * w); p++) begin
            if (word_at(w, p) == v) return p;
        end
        return -1;
    endfunction

    task automatic model_step(input int k, input bit r, input bit e, input bit u,
                              input bit l, input int unsigned lv);
        int unsigned w, mask, v, c, n;
        int p;
        w    = m_w[k];
        n    = 2 * w;
        mask = (1 << w) - 1;
        v    = lv & mask;
        c    = m_cnt[k];
        if (!r) begin
            m_cnt[k] = 0; m_wrap[k] = 0; m_err[k] = 0;
        end else if (l) begin
            m_wrap[k] = 0;
            if (phase_of(w, v) >= 0) begin
                m_cnt[k] = v; m_err[k] = 0;
            end else begin
                m_cnt[k] = m_sc[k] ? 0 : v; m_err[k] = 1;
            end
        end else if (e) begin
            p = phase_of(w, c);
            if (p >= 0) begin
                m_wrap[k] = u ? (p == int'(n - 1)) : (p == 0);
                m_cnt[k]  = word_at(w, u ? (p + 1) % n : (p + n - 1) % n);
            end else begin
                m_wrap[k] = 0;
                m_err[k]  = 1;
                if (m_sc[k]) m_cnt[k] = 0;
                else if (u)  m_cnt[k] = ((c << 1) | ((~c >> (w - 1)) & 1)) & mask;
                else         m_cnt[k] = (c >> 1) | ((~c & 1) << (w - 1));
            end
        end else begin
            m_wrap[k] = 0;
        end
    endtask

    task automatic check_inst(input int k, input string name, input logic [31:0] c,
                              input logic [31:0] ph, input logic wr, input logic il,
                              input logic er);
        int p;
        p = phase_of(m_w[k], m_cnt[k]);
        check({name, ".cnt"}, c, m_cnt[k]);
        check({name, ".wrap"}, 32'(wr), 32'(m_wrap[k]));
        check({name, ".err"}, 32'(er), 32'(m_err[k]));
        check({name, ".illegal"}, 32'(il), 32'(p < 0));
        if (p >= 0) check({name, ".phase"}, ph, 32'(p));
    endtask

    // One clock: apply inputs, advance the model at the edge, check just after.
    task automatic cycle(input bit r, input bit e, input bit u, input bit l,
                         input logic [7:0] lv);
        rst = r; en = e; up = u; load = l; load_val = lv;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, r, e, u, l, 32'(lv));
        #1;
        check_inst(0, "a", 32'(cnt_a), 32'(phase_a), wrap_a, illegal_a, err_a);
        check_inst(1, "b", 32'(cnt_b), 32'(phase_b), wrap_b, illegal_b, err_b);
        check_inst(2, "c", 32'(cnt_c), 32'(phase_c), wrap_c, illegal_c, err_c);
    endtask

    initial begin
        logic [7:0] lv;
        rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;

        // Reset, then a full forward lap.
        cycle(0, 0, 1, 0, 8'h00);
        cycle(0, 0, 1, 0, 8'h00);
        check("rst.cnt", 32'(cnt_a), 32'h0);
        check("rst.err", 32'(err_b), 32'h0);
        for (int i = 0; i < 16; i++) begin
            cycle(1, 1, 1, 0, 8'h00);
            if (i == 7)  check("tp1.top", 32'(cnt_a), 32'hFF);
            if (i == 14) check("tp1.last", 32'(cnt_a), 32'h80);
        end
        check("tp1.cnt", 32'(cnt_a), 32'h00);
        check("tp1.wrap", 32'(wrap_a), 32'h1);

        // Reverse wrap and direction change.
        cycle(1, 1, 0, 0, 8'h00);
        check("tp2.rev_cnt", 32'(cnt_a), 32'h80);
        check("tp2.rev_phase", 32'(phase_a), 32'd15);
        check("tp2.rev_wrap", 32'(wrap_a), 32'h1);
        cycle(1, 1, 1, 0, 8'h00);
        check("tp2.fwd_wrap", 32'(wrap_a), 32'h1);
        cycle(1, 1, 1, 0, 8'h00);
        check("tp2.fwd_cnt", 32'(cnt_a), 32'h01);
        check("tp2.fwd_nowrap", 32'(wrap_a), 32'h0);

        // Enable gating and load-over-enable priority.
        for (int i = 0; i < 5; i++) cycle(1, 0, 1, 0, 8'h00);
        check("tp3.frozen", 32'(cnt_a), 32'h01);
        cycle(1, 1, 1, 1, 8'h0F);
        check("tp3.load_cnt", 32'(cnt_a), 32'h0F);
        check("tp3.load_phase", 32'(phase_a), 32'd4);

        // Illegal load in both correction modes, then a legal load.
        cycle(1, 0, 1, 1, 8'h5A);
        check("tp4.corr_cnt", 32'(cnt_a), 32'h00);
        check("tp4.corr_err", 32'(err_a), 32'h1);
        check("tp5.raw_cnt", 32'(cnt_b), 32'h5A);
        check("tp5.raw_illegal", 32'(illegal_b), 32'h1);
        cycle(1, 1, 1, 0, 8'h00);
        check("tp5.shift", 32'(cnt_b), 32'hB5);
        check("tp5.err_sticky", 32'(err_b), 32'h1);
        cycle(1, 1, 1, 0, 8'h00);
        cycle(1, 0, 1, 1, 8'h07);
        check("tp4.legal_err", 32'(err_a), 32'h0);
        check("tp4.legal_phase", 32'(phase_a), 32'd3);

        // Reset mid-sequence, then the WIDTH=2 lap.
        cycle(1, 0, 1, 1, 8'hF0);
        cycle(0, 1, 1, 0, 8'h00);
        check("tp6.rst_cnt", 32'(cnt_a), 32'h0);
        for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0, 8'h00);
        check("tp6.w2_cnt", 32'(cnt_c), 32'h0);
        check("tp6.w2_wrap", 32'(wrap_c), 32'h1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(1)) lv = 8'($urandom);
            else                   lv = 8'(word_at(8, $urandom_range(15)));
            cycle(($urandom_range(63) != 0), ($urandom_range(3) != 0),
                  1'($urandom_range(1)), ($urandom_range(7) == 0), lv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/twist_counter_gen.md
Name: twist_counter_gen

Overview:
- Parametrised Johnson (twisted-ring) counter; successor to the fixed 8-bit twist counter.
- Adds:
  - configurable width
  - count enable and up/down direction
  - parallel load
  - decoded phase index and wrap pulse
  - illegal-state detection with optional self-correction
- Used as a low-glitch sequencer / phase generator inside the comm datapath.

Parameters:
- WIDTH, 8, counter width in bits; sequence length 2*WIDTH; legal range WIDTH >= 2.
- SELF_CORRECT, 1, 1 = force illegal states back to all-zeros; 0 = shift illegal states unchanged, flag only.
- PW, $clog2(2*WIDTH), phase output width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- en  in  1  advance one step this cycle.
- up  in  1  1 = forward step, 0 = reverse step; sampled only when en=1.
- load  in  1  parallel load of load_val this cycle.
- load_val  in  WIDTH  value to load.
- cnt  out  WIDTH  registered Johnson word.
- phase  out  PW  index 0..2*WIDTH-1 of cnt; combinational decode of cnt.
- wrap  out  1  registered one-cycle pulse, sequence crossed its end.
- illegal  out  1  combinational: cnt is not a legal Johnson word.
- err  out  1  registered sticky: illegal state encountered.

Behaviour:
- Priority per rising edge: rst=0 > load > en > hold.
- Reset (rst=0 at edge):
  - cnt=0, wrap=0, err=0.
  - Hence phase=0 and illegal=0.
- Forward step: cnt <= {cnt[WIDTH-2:0], ~cnt[WIDTH-1]}.
  - WIDTH=8 sequence: 0x00,0x01,0x03,...,0xFF,0xFE,...,0x80,0x00.
- Reverse step: cnt <= {~cnt[0], cnt[WIDTH-1:1]}, the exact inverse of the forward step.
- Legality:
  - Legal iff the count of i in 0..WIDTH-2 with cnt[i] != cnt[i+1] is <= 1.
  - Exactly 2*WIDTH legal words.
- Phase decode:
  - cnt[WIDTH-1]=0: phase = number of ones in cnt.
  - cnt[WIDTH-1]=1: phase = WIDTH + number of zeros in cnt.
  - Value is don't-care while illegal=1.
- wrap:
  - Set to 1 on an en step where the old phase = 2*WIDTH-1 and up=1, or the old phase = 0 and up=0.
  - Otherwise cleared at every edge.
  - High in the same cycle cnt shows the new value (0 after forward wrap, 0x80-style top word after reverse wrap).
  - Never set by load or self-correction.
- Illegal handling (en=1, load=0, illegal=1):
  - SELF_CORRECT=1: cnt <= 0, wrap <= 0.
  - SELF_CORRECT=0: normal shift applied to the illegal word.
  - Either mode: err <= 1.
- Load:
  - cnt <= load_val, wrap <= 0, err <= 0.
  - If load_val is illegal and SELF_CORRECT=1: cnt <= 0 and err <= 1 instead.
  - Load with en=1 in the same cycle: load wins, no step taken.
- Hold (en=0, load=0): cnt unchanged, wrap <= 0, err unchanged; illegal is still reported.
- Sticky err:
  - Set by either condition above.
  - Cleared only by reset or a legal load.
  - A simultaneous clear and set resolves to set.
- Mid-operation:
  - Reset deasserted → counting resumes from 0 on the first en edge.
  - Reset asserted mid-sequence → discards state at the next edge.
- No combinational path from inputs to any registered output; illegal and phase depend only on cnt.

Test Plan:
1. Reset then forward run (WIDTH=8):
   - Stimulus: rst=0 two cycles, rst=1, en=1, up=1 for 16 cycles.
   - Required: cnt walks 0x00→0x01→0x03→...→0xFF→0xFE→...→0x80→0x00; phase 0..15 then 0; wrap=1 exactly in the cycle cnt returns to 0x00; illegal=0 throughout.
2. Reverse and direction change:
   - Stimulus: from 0x00 with up=0, one step.
   - Required: cnt=0x80, phase=15, wrap=1.
   - Continue: next up=1 step → cnt=0x00, phase=0, wrap=1; next up=1 step → cnt=0x01, wrap=0.
3. Enable gating and load priority:
   - Stimulus: en=0 for 5 cycles.
   - Required: cnt frozen, wrap=0.
   - Then load=1, en=1, load_val=0x0F: next cnt=0x0F, phase=4 (no step), wrap=0.
4. Illegal load with SELF_CORRECT=1:
   - Stimulus: load_val=0x5A.
   - Required: cnt=0x00, err=1.
   - Then en steps: err stays 1. Legal load 0x07: err=0, phase=3.
5. Illegal state with SELF_CORRECT=0:
   - Stimulus: load 0x5A.
   - Required: cnt=0x5A, illegal=1, err=1.
   - Forward step: cnt=0xB5, err stays 1.
6. Reset mid-sequence and WIDTH=2 build:
   - Stimulus: rst=0 at cnt=0xF0.
   - Required: next edge cnt=0, wrap=0, err=0.
   - WIDTH=2 forward run: 00→01→11→10→00, period 4, wrap on return to 00.
